// File: rtl/xor_64bit.sv
// Y-86 xorq unit: per-bit XOR slices and registered result with ZF/SF/OF, 1-cycle latency.
// No backpressure: accepts a new operation every cycle; bubbles hold the flags.

module xor_bit_slice (
  input  logic i_a,
  input  logic i_b,
  output logic o_y
);
  assign o_y = i_a ^ i_b;
endmodule

module xor_64bit #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  output logic             zf,
  output logic             sf,
  output logic             of,
  output logic [WIDTH-1:0] comb_result
);

  logic [WIDTH-1:0] w_xor;
  logic             w_zero;
  logic [WIDTH-1:0] r_result;
  logic             r_valid;
  logic             r_zf;
  logic             r_sf;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slice
    xor_bit_slice u_slice (
      .i_a (a[gi]),
      .i_b (b[gi]),
      .o_y (w_xor[gi])
    );
  end

  assign w_zero = (w_xor == '0);

  // Flags only move on a valid op so the CC stage sees stable codes across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_valid  <= 1'b0;
      r_zf     <= 1'b1;
      r_sf     <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_result <= w_xor;
        r_zf     <= w_zero;
        r_sf     <= w_xor[WIDTH-1];
      end
    end
  end

  assign comb_result = w_xor;
  assign result      = r_result;
  assign out_valid   = r_valid;
  assign zf          = r_zf;
  assign sf          = r_sf;
  assign of          = 1'b0;

endmodule

// File: tb/tb_xor_64bit.sv
// Randomized self-checking bench for xor_64bit against a behavioural xorq model.

module tb_xor_64bit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [63:0] a;
  logic [63:0] b;
  logic [63:0] result;
  logic        out_valid;
  logic        zf;
  logic        sf;
  logic        of;
  logic [63:0] comb_result;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] exp_res;
  logic        exp_zf;
  logic        exp_sf;
  logic        exp_vld;

  xor_64bit #(.WIDTH(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .a           (a),
    .b           (b),
    .result      (result),
    .out_valid   (out_valid),
    .zf          (zf),
    .sf          (sf),
    .of          (of),
    .comb_result (comb_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".result"},    result,          exp_res);
    check_eq({tag, ".out_valid"}, 64'(out_valid),  64'(exp_vld));
    check_eq({tag, ".zf"},        64'(zf),         64'(exp_zf));
    check_eq({tag, ".sf"},        64'(sf),         64'(exp_sf));
    check_eq({tag, ".of"},        64'(of),         64'd0);
  endtask

  // Drive one operation, check forwarding path, clock it, check the registered view.
  task automatic apply(input string tag, input logic [63:0] va, input logic [63:0] vb,
                       input logic vv);
    logic [63:0] x;
    a        = va;
    b        = vb;
    in_valid = vv;
    x        = va ^ vb;
    #1;
    check_eq({tag, ".comb"}, comb_result, x);
    @(posedge clk);
    #1;
    exp_vld = vv;
    if (vv) begin
      exp_res = x;
      exp_zf  = (x == 64'd0);
      exp_sf  = ($signed(x) < 0);
    end
    check_outputs(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    exp_res  = '0;
    exp_zf   = 1'b1;
    exp_sf   = 1'b0;
    exp_vld  = 1'b0;

    #12;
    check_outputs("reset");
    rst_n = 1'b1;

    apply("t1_zero",   64'h0, 64'h0, 1'b1);
    apply("t2_small",  64'h1, 64'h5, 1'b1);
    apply("t3_mixed",  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1);
    apply("t4_mixed",  64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1);
    check_eq("t4_value", result, 64'h8000_0000_0000_0004);
    apply("t5_bubble", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0);
    apply("t5_bubble2", 64'hFFFF_0000_FFFF_0000, 64'h0, 1'b0);

    // Mid-cycle async reset must clear state without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    exp_res = '0;
    exp_zf  = 1'b1;
    exp_sf  = 1'b0;
    exp_vld = 1'b0;
    check_outputs("t5_async_rst");
    check_eq("t5_rst_comb", comb_result, 64'hFFFF_0000_FFFF_0000);
    @(posedge clk);
    #1;
    check_outputs("t5_rst_held");
    rst_n = 1'b1;

    apply("eq_operands", 64'hDEAD_BEEF_CAFE_F00D, 64'hDEAD_BEEF_CAFE_F00D, 1'b1);
    apply("not_operand", 64'h0F0F_1234_0000_FFFF, ~64'h0F0F_1234_0000_FFFF, 1'b1);
    check_eq("all_ones", result, 64'hFFFF_FFFF_FFFF_FFFF);
    apply("neg_neg",     64'h8000_0000_0000_0001, 64'hC000_0000_0000_0000, 1'b1);
    apply("pos_pos",     64'h7000_0000_0000_0000, 64'h0000_0000_0000_0007, 1'b1);

    for (int i = 0; i < 1000; i++) begin
      logic [63:0] ra;
      logic [63:0] rb;
      logic        rv;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if ($urandom_range(0, 15) == 0) rb = ra;
      rv = ($urandom_range(0, 7) != 0);
      apply("rand", ra, rb, rv);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
